press_conditioner: RTL and testbench

//  Front end for the tug-of-war playfield. It turns the two raw, bouncy, active-low

---
 rtl/tug_pkg.sv | 13 +
 rtl/press_channel.sv | 86 ++++++++
 rtl/press_conditioner.sv | 43 ++++
 tb/tb_press_conditioner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and defaults for the tug-of-war playfield front end.
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD,
        RELEASING
    } press_state_t;

    localparam int DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/press_channel.sv
// One player key: 2-flop synchroniser, debounce FSM and stability counter.
// 'fire' is combinational and marks the ARMING->HELD transition.
module press_channel
    import tug_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic fire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             kp;
    logic [CNT_W-1:0] cnt;
    press_state_t     state;

    // Synchroniser resets to "released" so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign kp   = ~sync2;
    assign fire = (state == ARMING) && kp && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (kp) begin
                        state <= ARMING;
                        cnt   <= CNT_W'(1);
                    end
                end
                ARMING: begin
                    if (!kp) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Holding the key never re-fires; only a full debounced release re-arms.
                HELD: begin
                    if (!kp) begin
                        state <= RELEASING;
                        cnt   <= CNT_W'(1);
                    end
                end
                RELEASING: begin
                    if (kp) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/press_conditioner.sv
// Turns the two raw active-low player keys into clean one-cycle L/R press pulses.
// A press landing on both sides on the same edge is not a move and yields no pulse.
module press_conditioner
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    output logic L,
    output logic R
);

    logic fire_l;
    logic fire_r;

    press_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk   (clk),
        .reset (reset),
        .key_n (key_l_n),
        .fire  (fire_l)
    );

    press_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk   (clk),
        .reset (reset),
        .key_n (key_r_n),
        .fire  (fire_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= fire_l & ~fire_r;
            R <= fire_r & ~fire_l;
        end
    end

endmodule

// File: tb/tb_press_conditioner.sv
// Directed bench for press_conditioner with DEBOUNCE_CYCLES=4 and a 100-unit clock.
module tb_press_conditioner;

    logic clk;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic L;
    logic R;

    int checks   = 0;
    int failures = 0;

    press_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .key_l_n (key_l_n),
        .key_r_n (key_r_n),
        .L       (L),
        .R       (R)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic applyStimulus(input logic rst, input logic kl, input logic kr);
        reset   = rst;
        key_l_n = kl;
        key_r_n = kr;
    endtask

    task automatic checkOutput(input string tag, input logic exp_l, input logic exp_r);
        checks++;
        assert (L === exp_l) else begin
            failures++;
            $error("[TB] FAIL %s: L observed=%b expected=%b", tag, L, exp_l);
        end
        checks++;
        assert (R === exp_r) else begin
            failures++;
            $error("[TB] FAIL %s: R observed=%b expected=%b", tag, R, exp_r);
        end
    endtask

    // Advance n edges, sampling 10 units after each; the pulse indices are 1-based
    // edge counts from the call (0 means no pulse expected on that side).
    task automatic runCheck(input int n, input string tag, input int l_at, input int r_at);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #10;
            checkOutput($sformatf("%s[%0d]", tag, i), (i == l_at), (i == r_at));
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCheck(3, "reset", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(2, "idle", 0, 0);

        // Left held 20 cycles: exactly one pulse, 5 edges after the first edge seeing it.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(20, "left_hold", 6, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "left_release", 0, 0);

        // Right bounce never completes the debounce window.
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCheck(2, "bounce_a", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(1, "bounce_b", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCheck(2, "bounce_c", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(10, "bounce_d", 0, 0);

        // Clean press, short release, re-press: no second pulse until a full release.
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCheck(10, "right_press1", 0, 6);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(2, "right_short_rel", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCheck(10, "right_repress", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "right_full_rel", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCheck(10, "right_press2", 0, 6);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "right_rel2", 0, 0);

        // Simultaneous press is a tie; afterwards the left side still works alone.
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCheck(12, "tie", 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "tie_rel", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(10, "after_tie_left", 6, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "after_tie_rel", 0, 0);

        // Left held while right is pressed three times.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(10, "hold_left", 6, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            runCheck(8, $sformatf("indep_r%0d_press", k), 0, 6);
            applyStimulus(1'b0, 1'b0, 1'b1);
            runCheck(8, $sformatf("indep_r%0d_rel", k), 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "indep_rel_left", 0, 0);

        // Reset at ARMING cnt=2, then again during the L-high cycle.
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(4, "arm_cnt2", 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCheck(1, "rst_arming", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(6, "rearm", 6, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCheck(1, "rst_pulse", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCheck(10, "post_rst_hold", 6, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCheck(8, "final_rel", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
